// File: rtl/pipelined_control_unit.sv
// Registered instruction decoder with memory-wait and branch-flush states.
// Define CTRL_COND_SHIFT_EN to make S-type op2=1x flag-conditioned shifts instead of NOPs.
module pipelined_control_unit #(
    parameter int unsigned IW      = 9,
    parameter int unsigned LUT_W   = 4,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [IW-1:0]      instr,
    input  logic               equal,
    input  logic               lessThan,
    input  logic               mem_ack,
    output logic               ctrl_valid,
    output logic               branchEnable,
    output logic               memWrite,
    output logic               memRead,
    output logic               regWrite,
    output logic               LUTen,
    output logic               shiftEnable,
    output logic               shiftDirection,
    output logic [LUT_W-1:0]   LUTIndex,
    output logic [2:0]         Aluop,
    output logic [SHAMT_W-1:0] shiftAmount
);

    localparam int unsigned LowW = IW - 5;

    typedef enum logic [1:0] {StIdle, StMemWait, StFlush} state_e;

    typedef struct packed {
        logic               valid;
        logic               branch;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic               lut_en;
        logic               shift_en;
        logic               shift_dir;
        logic               is_load;
        logic [LUT_W-1:0]   lut_index;
        logic [2:0]         aluop;
        logic [SHAMT_W-1:0] shamt;
    } ctrl_t;

    logic [1:0]      itype;
    logic [2:0]      op3;
    logic [1:0]      op2;
    logic [LowW-1:0] low;

    assign itype = instr[IW-1:IW-2];
    assign op3   = instr[IW-3:IW-5];
    assign op2   = instr[IW-3:IW-4];
    assign low   = instr[IW-6:0];

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    ctrl_t  dec;
    logic   dec_mem;
    logic   taken;
    logic   shift_go;

    // Decode of the instruction currently presented; only used on an accept edge.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec_mem   = 1'b0;
        taken     = 1'b0;
        shift_go  = 1'b0;
        unique case (itype)
            2'b00: begin
                dec.aluop     = op3;
                dec.reg_write = (low[3:0] <= 4'd4);
            end
            2'b01: begin
                dec_mem = ~op3[2];
                unique case (op3)
                    3'b000: dec.mem_write = 1'b1;
                    3'b001: begin
                        dec.mem_read = 1'b1;
                        dec.is_load  = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        dec.mem_read  = 1'b1;
                        dec.lut_en    = 1'b1;
                        dec.lut_index = low[LUT_W-1:0];
                    end
                    3'b100, 3'b101: begin
                        dec.reg_write = 1'b1;
                        dec.lut_index = low[LUT_W-1:0];
                    end
                    3'b110:  dec.reg_write = 1'b1;
                    default: ;
                endcase
            end
            2'b10: begin
                unique case (op2)
                    2'b00:   taken = equal;
                    2'b01:   taken = lessThan;
                    2'b10:   taken = equal | lessThan;
                    default: taken = 1'b1;
                endcase
                dec.branch = taken;
            end
            default: begin
`ifdef CTRL_COND_SHIFT_EN
                unique case (op2)
                    2'b00, 2'b01: shift_go = 1'b1;
                    2'b10:        shift_go = equal;
                    default:      shift_go = lessThan;
                endcase
`else
                shift_go = ~op2[1];
`endif
                if (shift_go) begin
                    dec.shift_en  = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.shift_dir = op2[0];
                    dec.shamt     = SHAMT_W'(low);
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    ctrl_d = dec;
                    if (dec_mem) begin
                        state_d = StMemWait;
                    end else if (dec.branch) begin
                        state_d = StFlush;
                    end
                end
            end
            StMemWait: begin
                // Strobes hold until the cycle that carries the ack, then drop.
                if (mem_ack) begin
                    state_d = StIdle;
                end else begin
                    ctrl_d = ctrl_q;
                end
            end
            StFlush: begin
                if (instr_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign instr_ready    = (state_q != StMemWait);
    assign ctrl_valid     = ctrl_q.valid;
    assign branchEnable   = ctrl_q.branch;
    assign memWrite       = ctrl_q.mem_write;
    assign memRead        = ctrl_q.mem_read;
    // A load writes back only in the cycle its ack arrives.
    assign regWrite       = ctrl_q.reg_write | (ctrl_q.is_load & mem_ack);
    assign LUTen          = ctrl_q.lut_en;
    assign shiftEnable    = ctrl_q.shift_en;
    assign shiftDirection = ctrl_q.shift_dir;
    assign LUTIndex       = ctrl_q.lut_index;
    assign Aluop          = ctrl_q.aluop;
    assign shiftAmount    = ctrl_q.shamt;

endmodule

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 SHALL have parameter IW, default 9, instruction width (legal range 9..16).
REQ-002 SHALL have parameter LUT_W, default 4, LUTIndex width (legal range 1..IW-5).
REQ-003 SHALL have parameter SHAMT_W, default 5, shiftAmount width (legal range 1..8).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports instr_valid  input  1, instr_ready  output  1, instr  input  IW: instruction handshake.
REQ-007 SHALL have ports equal  input  1 and lessThan  input  1: compare flags, sampled at accept.
REQ-008 SHALL have port mem_ack  input  1  memory completion.
REQ-009 SHALL have port ctrl_valid  output  1  control word valid this cycle.
REQ-010 SHALL have 1-bit outputs branchEnable, memWrite, memRead, regWrite, LUTen, shiftEnable and shiftDirection.
REQ-011 SHALL have outputs LUTIndex (LUT_W), Aluop (3) and shiftAmount (SHAMT_W).

Function
REQ-012 Fields SHALL be: type=instr[IW-1:IW-2]; op3=instr[IW-3:IW-5]; op2=instr[IW-3:IW-4]; low=instr[IW-6:0]; R=00, M=01, B=10, S=11.
REQ-013 Accept SHALL occur when instr_valid&&instr_ready; instr_ready=1 in IDLE and FLUSH, 0 in MEM_WAIT.
REQ-014 Control outputs SHALL be registered: instruction accepted at edge N drives outputs, with ctrl_valid=1, during cycle N+1; all outputs SHALL be 0 in any cycle without a valid word.
REQ-015 R-type SHALL set Aluop=op3 and set regWrite=1 only when low[3:0] is 0..4; other low values SHALL produce regWrite=0.
REQ-016 M op3=000 (store) SHALL assert memWrite; op3=001 (load) SHALL assert memRead.
REQ-017 M op3=010 or 011 SHALL assert memRead and LUTen, with LUTIndex=low[LUT_W-1:0].
REQ-018 M op3=100 or 101 SHALL pulse regWrite with LUTIndex=low[LUT_W-1:0]; op3=110 SHALL pulse regWrite; op3=111 SHALL be a NOP with ctrl_valid=1.
REQ-019 Memory ops (op3 000-011) SHALL enter MEM_WAIT and hold the strobes and ctrl_valid from N+1 through the first cycle with mem_ack=1 inclusive, then return to IDLE.
REQ-020 A load (op3=001) SHALL assert regWrite only in the ack cycle.
REQ-021 mem_ack=1 in the first strobe cycle SHALL complete the op with a single-cycle strobe; mem_ack outside MEM_WAIT SHALL be ignored.
REQ-022 B op2 SHALL select the taken condition: 00 equal, 01 lessThan, 10 equal||lessThan, 11 always; flags SHALL be sampled at the accept edge.
REQ-023 A taken branch SHALL pulse branchEnable for one cycle and enter FLUSH.
REQ-024 FLUSH SHALL discard the next accepted instruction (no outputs, ctrl_valid=0), then return to IDLE, and SHALL persist while instr_valid=0; a not-taken branch SHALL give ctrl_valid=1 with branchEnable=0.
REQ-025 S op2=00 (LSL) and 01 (LSR) SHALL assert shiftEnable and regWrite, with shiftDirection=op2[0] and shiftAmount=low zero-extended or truncated to SHAMT_W.
REQ-026 Back-to-back non-memory instructions SHALL sustain one per cycle.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, set every control output and ctrl_valid to 0, and set instr_ready to 1 within the same cycle.
REQ-028 Reset during MEM_WAIT or FLUSH SHALL drop strobes immediately and abandon the pending op; a later mem_ack SHALL be ignored.

Configuration
REQ-029 With macro CTRL_COND_SHIFT_EN defined, S op2=10 (LSI) SHALL act as LSL only if equal and op2=11 (RSI) SHALL act as LSR only if lessThan, with the flag sampled at accept; a false condition SHALL give ctrl_valid=1 with all strobes 0.
REQ-030 Without CTRL_COND_SHIFT_EN, S op2=1x SHALL decode as NOP (ctrl_valid=1, all strobes 0), independent of the flags.

Verification
REQ-031 Reset then instr=0_0000_011 (ADD) accepted -> next cycle ctrl_valid=1, regWrite=1, Aluop=000, then all 0.
REQ-032 Store 01_000_0000 with mem_ack at 3rd strobe cycle -> memWrite high 3 cycles, instr_ready low 3 cycles.
REQ-033 BEQ 10_00_xxxxx with equal=1, followed by ADD -> branchEnable 1-cycle pulse, ADD dropped, third instruction decoded normally.
REQ-034 LSI 11_10_00011 with equal=1 -> shiftEnable=1, shiftAmount=3 with macro; all strobes 0 without macro.
REQ-035 Load 01_001_0000, rst_n low in 2nd wait cycle, then mem_ack -> memRead drops asynchronously, no regWrite, instr_ready=1.
